cam_i2c_target: RTL and testbench
=================================

# cam_i2c_target

I2C target (slave) that terminates the camera-configuration bus from the controller side of the link. It decodes 7-bit-addressed transactions carrying a 16-bit register address followed by 8-bit data bytes, then issues single-cycle write strobes and read requests to an attached register file. It is used as the camera-side model in simulation and as an FPGA-hosted camera register emulator. SCL and SDA are oversampled by a fast system clock.

## Interface
Parameters:
- SLAVE_ADDR, 7'h10, 7-bit device address this target answers to.

Ports:
- clk  input  1  system clock; must be ≥ 16× SCL frequency (≥ 6.4 MHz for 400 kHz).
- reset_n  input  1  asynchronous, active-low reset.
- scl_i  input  1  raw SCL pin level.
- sda_i  input  1  raw SDA pin level.
- sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
- wr_en  output  1  one-cycle write strobe.
- wr_addr  output  16  register address for wr_en.
- wr_data  output  8  write data for wr_en.
- rd_en  output  1  one-cycle read request.
- rd_addr  output  16  register address for rd_en.
- rd_data  input  8  read data, valid exactly 1 clk after rd_en.
- busy  output  1  high from START to STOP for a matched address.

## Operation
- Input conditioning: scl_i and sda_i each pass through a 2-FF synchronizer. The previous synchronized sample is kept for edge detection.
- START: synced SDA falls while SCL is high. Accepted in any state, including repeated START. Clears the bit counter and enters ADDR. The register pointer is kept.
- STOP: synced SDA rises while SCL is high. Enters IDLE from any state, releases sda_oe, clears busy.
- Data is sampled on the SCL rising edge, MSB first. sda_oe changes only on the SCL falling edge.
- States:
  - IDLE.
  - ADDR: 8 bits = address[6:0] + R/W.
  - ADDR_ACK:
    - Address match, W: ACK, then REG_HI.
    - Address match, R: ACK, then RDATA.
    - Mismatch: no ACK, then WAIT_STOP.
  - REG_HI → ACK_HI → REG_LO → ACK_LO → WDATA: 16-bit pointer, high byte first, each byte ACKed.
  - WDATA → WACK: after the 8th bit, pulse wr_en with wr_addr = pointer and wr_data = byte. ACK, pointer += 1, return to WDATA.
  - RDATA:
    - On entry (on the falling edge that ends the previous ACK), pulse rd_en with rd_addr = pointer.
    - Load rd_data into the shift register the next clk.
    - Drive bit 7 before the next SCL rise, and each following bit after each SCL fall.
    - A 1 bit means release, never drive high.
    - After 8 bits, release SDA and go to RACK.
  - RACK: sample the controller's bit. ACK (0): pointer += 1, RDATA. NACK (1): WAIT_STOP.
  - WAIT_STOP: ignores traffic until STOP or START.
- Pointer arithmetic: 16-bit, wraps 16'hFFFF → 16'h0000.
- Pointer load:
  - The pointer loads only after ACK_LO. A write header with no data bytes (a STOP right after the register address) sets the pointer for a following read.
  - A transaction cut short after REG_HI leaves the pointer unchanged.

## Timing
- Reset values: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_en=0, rd_addr=0, busy=0, state IDLE, pointer 0.
- reset_n low releases SDA combinationally-asynchronously (flop clear), even mid-ACK.
- Input latency: pin to internal edge detect is 3 clk.
- ACK drive:
  - sda_oe asserts on the first clk after the synced SCL fall that follows the 8th bit.
  - It deasserts on the first clk after the next synced SCL fall.
- wr_en is asserted 1 clk after the synced SCL rise that samples data bit 0.
- rd_en to rd_data capture is 1 clk. The first read bit is driven within 3 clk of rd_en.
- Simultaneous events: START/STOP detection takes priority over bit sampling in the same clk.
- An SDA change while SCL is high is never treated as data.
- wr_en and rd_en are never asserted in the same clk.

## Test plan
- Write, 100 kHz SCL, clk 50 MHz. Sequence: START, 0x20 (0x10,W), 0x01, 0x00, 0x01, STOP. Required: ACKs on all 4 bytes, exactly one wr_en with wr_addr=0x0100 and wr_data=0x01, busy high START→STOP.
- Burst write at 400 kHz. Sequence: pointer 0xFFFE, data 0xAA, 0xBB, 0xCC. Required: wr_en ×3 at addresses 0xFFFE, 0xFFFF, 0x0000 (wrap).
- Address mismatch: 0x22 (0x11,W). Required: SDA never driven, no wr_en/rd_en, busy 0, state IDLE after STOP.
- Random read. Sequence: write header 0x30,0x0A, repeated START, 0x21, two bytes with rd_data model returning 0x5A then 0xC3, controller ACK then NACK, STOP. Required:
  - rd_addr 0x300A then 0x300B.
  - Bits seen on SDA: 0x5A, 0xC3.
  - SDA released after the NACK.
- Abort: START inside a WDATA byte after 4 bits. Required: no wr_en, new address phase decoded correctly.
- Reset: reset_n pulsed low while sda_oe=1 during ADDR_ACK. Required: sda_oe=0 in the same cycle, all outputs at reset values, next transaction decodes normally.

Source files
------------

// File: rtl/cam_i2c_target.sv
// cam_i2c_target: oversampled I2C target with 16-bit register pointer.
// It drives single-cycle write strobes and read requests into a register file.
module cam_i2c_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG_HI, ACK_HI, REG_LO, ACK_LO,
        WDATA, WACK, RDATA, RACK, WAIT_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_q, scl_d, sda_q, sda_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d, hi_q, hi_d;
    logic [15:0] ptr_q, ptr_d;
    logic        rw_q, rw_d, ld_q, ld_d;
    logic        sda_oe_q, sda_oe_d, busy_q, busy_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [15:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        sda_s, rise, fall, start, stop;

    // index 1 is the synchronized level, index 2 the previous sample
    assign sda_s = sda_q[1];
    assign rise  = scl_q[1] & ~scl_q[2];
    assign fall  = ~scl_q[1] & scl_q[2];
    assign start = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
    assign stop  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

    always_comb begin
        scl_d     = {scl_q[1:0], scl_i};
        sda_d     = {sda_q[1:0], sda_i};
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        hi_d      = hi_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        ld_d      = rd_en_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        if (start) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else if (stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            // rd_data is valid the clk after rd_en; present bit 7 right away
            if (ld_q && state_q == RDATA) begin
                sh_d     = rd_data;
                sda_oe_d = ~rd_data[7];
            end
            case (state_q)
                ADDR, REG_HI, REG_LO, WDATA: begin
                    if (rise && cnt_q != 4'd8) begin
                        sh_d  = {sh_q[6:0], sda_s};
                        cnt_d = cnt_q + 4'd1;
                        if (state_q == WDATA && cnt_q == 4'd7) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = {sh_q[6:0], sda_s};
                            ptr_d     = ptr_q + 16'd1;
                        end
                    end else if (fall && cnt_q == 4'd8) begin
                        cnt_d    = 4'd0;
                        sda_oe_d = 1'b1;
                        state_d  = state_q == REG_HI ? ACK_HI :
                                   state_q == REG_LO ? ACK_LO :
                                   state_q == WDATA  ? WACK : ADDR_ACK;
                        if (state_q == REG_HI) hi_d = sh_q;
                        if (state_q == ADDR) begin
                            rw_d = sh_q[0];
                            if (sh_q[7:1] != SLAVE_ADDR) begin
                                state_d  = WAIT_STOP;
                                sda_oe_d = 1'b0;
                            end else begin
                                busy_d = 1'b1;
                            end
                        end
                    end
                end
                ADDR_ACK, ACK_HI, ACK_LO, WACK: begin
                    if (fall) begin
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                        state_d  = state_q == ACK_HI ? REG_LO :
                                   state_q == ADDR_ACK ? (rw_q ? RDATA : REG_HI) : WDATA;
                        if (state_q == ACK_LO) ptr_d = {hi_q, sh_q};
                        if (state_q == ADDR_ACK && rw_q) begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = ptr_q;
                        end
                    end
                end
                RDATA: begin
                    if (rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                            state_d  = RACK;
                        end else begin
                            sh_d     = {sh_q[6:0], 1'b0};
                            sda_oe_d = ~sh_q[6];
                        end
                    end
                end
                RACK: begin
                    if (rise) begin
                        if (sda_s) begin
                            state_d = WAIT_STOP;
                        end else begin
                            ptr_d = ptr_q + 16'd1;
                            cnt_d = 4'd1;
                        end
                    end else if (fall && cnt_q == 4'd1) begin
                        state_d   = RDATA;
                        cnt_d     = 4'd0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = ptr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_q     <= 3'b111;
            sda_q     <= 3'b111;
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            sh_q      <= 8'd0;
            hi_q      <= 8'd0;
            ptr_q     <= 16'd0;
            rw_q      <= 1'b0;
            ld_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 16'd0;
            wr_data_q <= 8'd0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= 16'd0;
        end else begin
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            hi_q      <= hi_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            ld_q      <= ld_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
endmodule

// File: tb/tb_cam_i2c_target.sv
// tb_cam_i2c_target: directed I2C controller bench for cam_i2c_target.
module tb_cam_i2c_target;
    logic        clk = 1'b0, reset_n = 1'b0, scl_c = 1'b1, sda_c = 1'b1;
    logic        sda_oe, wr_en, rd_en, busy, sda_line;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0]  wr_data, rd_data = 8'h00;
    int          vecs = 0, errs = 0, q = 625;
    int          wn = 0, rn = 0, oen = 0, bothn = 0;
    logic [15:0] wa [32];
    logic [15:0] ra [32];
    logic [7:0]  wd [32];

    assign sda_line = sda_c & ~sda_oe;

    always #10 clk = ~clk;

    cam_i2c_target #(.SLAVE_ADDR(7'h10)) dut (
        .clk(clk), .reset_n(reset_n), .scl_i(scl_c), .sda_i(sda_line),
        .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    // register file: registered read, two known locations
    always @(posedge clk)
        if (rd_en) rd_data <= rd_addr == 16'h300A ? 8'h5A : rd_addr == 16'h300B ? 8'hC3 : 8'hEE;

    always @(negedge clk) begin
        if (wr_en && wn < 32) begin
            wa[5'(wn)] <= wr_addr;
            wd[5'(wn)] <= wr_data;
            wn <= wn + 1;
        end
        if (rd_en && rn < 32) begin
            ra[5'(rn)] <= rd_addr;
            rn <= rn + 1;
        end
        if (sda_oe) oen <= oen + 1;
        if (wr_en && rd_en) bothn <= bothn + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_x(input logic b, output logic r);
        sda_c = b;
        #(q);
        scl_c = 1'b1;
        #(q);
        r = sda_line;
        #(q);
        scl_c = 1'b0;
        #(q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        bit_x(1'b1, ack);
    endtask

    task automatic rbyte(input logic a, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        bit_x(a, r);
    endtask

    task automatic start_c();
        sda_c = 1'b1;
        #(q);
        scl_c = 1'b1;
        #(q);
        sda_c = 1'b0;
        #(q);
        scl_c = 1'b0;
        #(q);
    endtask

    task automatic stop_c();
        sda_c = 1'b0;
        #(q);
        scl_c = 1'b1;
        #(q);
        sda_c = 1'b1;
        #(2 * q);
    endtask

    initial begin
        logic a, acc, r;
        logic [7:0] d;
        int w0, r0, o0;
        repeat (5) @(posedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_oe", 32'(sda_oe), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_rd_en", 32'(rd_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_addrs", {wr_addr, rd_addr}, 0);
        check("rst_wdata", 32'(wr_data), 0);

        // single write at 100 kHz
        q = 2500;
        w0 = wn;
        start_c();
        wbyte(8'h20, a); check("t1_ack_dev", 32'(a), 0);
        check("t1_busy", 32'(busy), 1);
        wbyte(8'h01, a); check("t1_ack_hi", 32'(a), 0);
        wbyte(8'h00, a); check("t1_ack_lo", 32'(a), 0);
        wbyte(8'h01, a); check("t1_ack_data", 32'(a), 0);
        check("t1_busy_end", 32'(busy), 1);
        stop_c();
        check("t1_wr_cnt", wn - w0, 1);
        check("t1_wr_addr", 32'(wa[5'(w0)]), 32'h0100);
        check("t1_wr_data", 32'(wd[5'(w0)]), 32'h01);
        check("t1_busy_stop", 32'(busy), 0);

        // burst write with pointer wrap at 400 kHz
        q = 625;
        w0 = wn;
        acc = 1'b0;
        start_c();
        wbyte(8'h20, a); acc |= a;
        wbyte(8'hFF, a); acc |= a;
        wbyte(8'hFE, a); acc |= a;
        wbyte(8'hAA, a); acc |= a;
        wbyte(8'hBB, a); acc |= a;
        wbyte(8'hCC, a); acc |= a;
        stop_c();
        check("t2_acks", 32'(acc), 0);
        check("t2_wr_cnt", wn - w0, 3);
        check("t2_addr0", 32'(wa[5'(w0)]), 32'hFFFE);
        check("t2_addr1", 32'(wa[5'(w0 + 1)]), 32'hFFFF);
        check("t2_addr2", 32'(wa[5'(w0 + 2)]), 32'h0000);
        check("t2_data", {8'h0, wd[5'(w0)], wd[5'(w0 + 1)], wd[5'(w0 + 2)]}, 32'h00AABBCC);

        // address mismatch
        w0 = wn; r0 = rn; o0 = oen;
        start_c();
        wbyte(8'h22, a); check("t3_nack", 32'(a), 1);
        check("t3_busy", 32'(busy), 0);
        wbyte(8'h55, a); check("t3_nack_data", 32'(a), 1);
        stop_c();
        check("t3_oe_cnt", oen - o0, 0);
        check("t3_strobes", (wn - w0) + (rn - r0), 0);
        check("t3_busy_stop", 32'(busy), 0);

        // random read via write header and repeated start
        w0 = wn; r0 = rn;
        acc = 1'b0;
        start_c();
        wbyte(8'h20, a); acc |= a;
        wbyte(8'h30, a); acc |= a;
        wbyte(8'h0A, a); acc |= a;
        start_c();
        wbyte(8'h21, a); acc |= a;
        check("t4_acks", 32'(acc), 0);
        rbyte(1'b0, d); check("t4_byte0", 32'(d), 32'h5A);
        rbyte(1'b1, d); check("t4_byte1", 32'(d), 32'hC3);
        check("t4_released", 32'(sda_oe), 0);
        bit_x(1'b1, r); check("t4_line_idle", 32'(r), 1);
        stop_c();
        check("t4_rd_cnt", rn - r0, 2);
        check("t4_rd_addr0", 32'(ra[5'(r0)]), 32'h300A);
        check("t4_rd_addr1", 32'(ra[5'(r0 + 1)]), 32'h300B);
        check("t4_no_wr", wn - w0, 0);

        // abort: repeated start four bits into a data byte
        w0 = wn;
        start_c();
        wbyte(8'h20, a);
        wbyte(8'h12, a);
        wbyte(8'h34, a);
        bit_x(1'b1, r); bit_x(1'b0, r); bit_x(1'b1, r); bit_x(1'b0, r);
        start_c();
        check("t5_no_wr_abort", wn - w0, 0);
        wbyte(8'h20, a); check("t5_ack_dev", 32'(a), 0);
        wbyte(8'h00, a);
        wbyte(8'h10, a);
        wbyte(8'h77, a); check("t5_ack_data", 32'(a), 0);
        stop_c();
        check("t5_wr_cnt", wn - w0, 1);
        check("t5_wr", {wa[5'(w0)], 8'h0, wd[5'(w0)]}, 32'h0010_0077);

        // reset while the target drives the address ACK
        start_c();
        for (int i = 7; i >= 0; i--) bit_x(i == 5, r);
        sda_c = 1'b1;
        #(q);
        @(negedge clk);
        check("t6_oe_pre", 32'(sda_oe), 1);
        reset_n = 1'b0;
        #1;
        check("t6_oe_async", 32'(sda_oe), 0);
        check("t6_busy", 32'(busy), 0);
        check("t6_wr_regs", {wr_addr, 8'h0, wr_data}, 0);
        check("t6_rd_addr", 32'(rd_addr), 0);
        scl_c = 1'b1;
        repeat (5) @(posedge clk);
        reset_n = 1'b1;
        repeat (10) @(posedge clk);
        w0 = wn;
        acc = 1'b0;
        start_c();
        wbyte(8'h20, a); acc |= a;
        wbyte(8'h00, a); acc |= a;
        wbyte(8'h05, a); acc |= a;
        wbyte(8'h99, a); acc |= a;
        stop_c();
        check("t6_acks", 32'(acc), 0);
        check("t6_wr_cnt", wn - w0, 1);
        check("t6_wr", {wa[5'(w0)], 8'h0, wd[5'(w0)]}, 32'h0005_0099);
        check("both_strobes", bothn, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
